dispatch_ram_ctl: RTL

Access controller for the 2K x 17 dispatch RAM. It clears every entry after reset, then shares the single RAM access slot between two requesters: the CPU dispatch path (reads, and writes driven by dispatch-write) and the spy/debug port used by the console and loader. The CPU has priority, and a starvation counter guarantees the spy port makes progress. The block sits between the CPU dispatch logic and the dual-port RAM primitive, and drives that primitive's read and write controls.

---
 rtl/dispatch_ram_ctl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dispatch_ram_ctl.sv
// Access controller for the 2K x 17 dispatch RAM: clears the RAM after reset,
// then arbitrates the single access slot between the CPU dispatch path and the spy port.
module dispatch_ram_ctl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 17,
  parameter int STARVE = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              spy_req,
  input  logic              spy_wr,
  input  logic [ADDR_W-1:0] spy_addr,
  input  logic [DATA_W-1:0] spy_wdata,
  output logic              spy_ack,
  output logic [DATA_W-1:0] spy_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  typedef enum logic [1:0] {INIT, IDLE, SPY_RD, SPY_ACK} state_t;

  localparam logic [3:0]        STARVE_MAX = 4'(STARVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                init_done_q, init_done_d;
  logic [DATA_W-1:0]   spy_rdata_q, spy_rdata_d;

  logic cpu_acc;
  logic starved;

  assign cpu_acc   = cpu_rd | cpu_wr;
  assign starved   = (starve_cnt_q == STARVE_MAX);
  assign init_done = init_done_q;
  assign spy_rdata = spy_rdata_q;

  // NOTE: every output and *_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    starve_cnt_d = starve_cnt_q;
    init_done_d  = init_done_q;
    spy_rdata_d  = spy_rdata_q;
    cpu_stall    = 1'b0;
    spy_ack      = 1'b0;
    // CPU owns the slot unless a state below hands it elsewhere; write beats read.
    ram_addr     = cpu_addr;
    ram_wdata    = cpu_wdata;
    ram_we       = cpu_wr;
    ram_re       = cpu_rd & ~cpu_wr;

    unique case (state_q)
      INIT: begin
        ram_addr   = init_cnt_q;
        ram_wdata  = '0;
        ram_we     = 1'b1;
        ram_re     = 1'b0;
        cpu_stall  = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (spy_req && (!cpu_acc || starved)) begin
          cpu_stall    = starved;
          ram_addr     = spy_addr;
          ram_wdata    = spy_wdata;
          ram_we       = spy_wr;
          ram_re       = ~spy_wr;
          starve_cnt_d = '0;
          state_d      = spy_wr ? SPY_ACK : SPY_RD;
        end else if (spy_req) begin
          // Only reachable while below STARVE, so the increment cannot overshoot.
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      SPY_RD: begin
        spy_rdata_d = ram_q;
        state_d     = SPY_ACK;
      end
      SPY_ACK: begin
        spy_ack = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (!spy_req) starve_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      starve_cnt_q <= '0;
      init_done_q  <= 1'b0;
      spy_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      init_done_q  <= init_done_d;
      spy_rdata_q  <= spy_rdata_d;
    end
  end

endmodule
